uart_link_scheduler: RTL and testbench
======================================

Name: uart_link_scheduler

Overview:
- Sole owner of the car-link UART between the device top level and the UART core; sits between the mode-muxed control outputs (moving_state, barrier commands) and the UART core.
- Arbitrates three transmit requesters (barrier command, moving-state change, periodic refresh) onto the single tx channel and frames each byte.
- Validates and latches received detector bytes and raises link_lost on receive silence.

Parameters:
- REFRESH_CYCLES, 10_000_000, idle cycles before the current state is re-sent (100 ms at 100 MHz); must be ≥ 2.
- GAP_CYCLES, 16, mandatory idle cycles after each frame before the next launch; must be ≥ 1.
- RX_TIMEOUT, 50_000_000, cycles without rx_valid before link_lost asserts.

Ports:
- sys_clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-low reset
- power  in  1  engine power state; 0 forces the moving field to 4'b0000
- moving_state  in  4  current moving state from the mode mux
- place_req  in  1  one-cycle pulse: place barrier
- destroy_req  in  1  one-cycle pulse: destroy barrier
- tx_busy  in  1  UART core transmitting
- tx_data  out  8  frame byte to UART core
- tx_start  out  1  one-cycle launch strobe
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- detector  out  4  {back,right,left,front} = rx byte [3:0]
- detector_valid  out  1  at least one byte accepted since reset or since the last timeout
- link_lost  out  1  no rx_valid for RX_TIMEOUT cycles

Behaviour:
- Reset (rst=0, asynchronous): tx_data=8'h80, tx_start=0, detector=0, detector_valid=0, link_lost=0, FSM=IDLE, pending flags cleared, refresh and watchdog counters cleared, last_sent=4'b0000.
- eff_ms = power ? moving_state : 4'b0000. Frame byte = {2'b10, dst, plc, eff_ms_sampled}. eff_ms is sampled in the cycle the FSM leaves IDLE.
- Pending flags:
  - pend_dst is set by destroy_req; pend_plc is set by place_req.
  - A pulse arriving while its flag is already set is merged into that flag, not counted.
  - A flag is cleared only on the launch of the frame that carries it.
  - A pulse in the same cycle as that launch stays pending for the next frame.
- Requests, highest priority first:
  1. Barrier: pend_dst or pend_plc. dst and plc both go into one frame if both are pending.
  2. Change: eff_ms differs from last_sent.
  3. Refresh: refresh counter has reached REFRESH_CYCLES-1.
- Each frame carries eff_ms, so any frame satisfies change and refresh; it loads last_sent and clears the refresh counter.
- FSM:
  - IDLE: if any request is pending, go to LAUNCH. The refresh counter increments only in IDLE and saturates.
  - LAUNCH: one cycle; tx_start=1, tx_data=frame. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE. If tx_busy has not risen after 8 cycles, go to GAP; the frame counts as sent.
  - WAIT_DONE: wait for tx_busy=0, then go to GAP.
  - GAP: count GAP_CYCLES, then go to IDLE.
- tx_data holds its value from LAUNCH until the next LAUNCH.
- Latency: a request seen in IDLE at cycle N gives tx_start at cycle N+1.
- Receive path and watchdog:
  - On rx_valid: detector <= rx_data[3:0], detector_valid <= 1, link_lost <= 0, watchdog cleared. All updates take effect on the next edge.
  - Otherwise the watchdog increments. On reaching RX_TIMEOUT-1: link_lost <= 1, detector_valid <= 0, detector holds its last value, watchdog saturates.
  - rx_valid in the same cycle as the timeout wins; no timeout occurs.
- power 1→0 makes eff_ms differ from last_sent (unless it is already 0), so exactly one stop frame is queued.
- Barrier pulses are honoured while power=0.
- Reset asserted mid-frame aborts immediately. No partial state survives; tx_start is low out of reset.

Optional Feature:
- RX_FILTER_EN defined:
  - detector updates only when two consecutive rx_valid bytes have an identical [3:0].
  - The first byte after reset or timeout only arms the comparator.
  - detector_valid and link_lost follow any rx_valid as above; the watchdog is not filtered.
- RX_FILTER_EN undefined: every rx_valid updates detector directly.

Test Plan:
- Use REFRESH_CYCLES=20, GAP_CYCLES=4, RX_TIMEOUT=50, UART model with tx_busy high 10 cycles starting 1 cycle after tx_start.
- Release reset, power=1, moving_state=4'b0001 -> one tx_start with tx_data=8'h81; no second frame until the refresh point, about 20 idle cycles later (8'h81 again).
- destroy_req and place_req pulsed in the same cycle as moving_state changes to 4'b0010 mid-frame -> after GAP, one frame 8'hB2; pend flags clear; no extra change frame.
- place_req pulsed twice during one frame -> exactly one frame with tx_data[4]=1 follows; pulse in the LAUNCH cycle of a barrier frame -> second frame with the bit set.
- power 1→0 with moving_state=4'b1000 -> single frame 8'h80, then only refresh frames 8'h80.
- rx_valid with 8'hA5 -> detector=4'h5, detector_valid=1; then 50 idle cycles -> link_lost=1, detector_valid=0, detector=4'h5; next rx_valid clears link_lost.
- RX_FILTER_EN: rx bytes 8'h03, 8'h05, 8'h05 -> detector stays 0 until the third byte, then becomes 4'h5. Tie tx_busy low -> WAIT_BUSY exits to GAP after 8 cycles. Assert rst mid-WAIT_DONE -> all outputs at reset values.

Source files
------------

// File: rtl/uart_link_scheduler.sv
// Car-link UART owner: arbitrates barrier, change and refresh frames onto one tx channel
// and latches received detector bytes behind a silence watchdog. Optional: RX_FILTER_EN.
module uart_link_scheduler #(
  parameter int REFRESH_CYCLES = 10_000_000,
  parameter int GAP_CYCLES     = 16,
  parameter int RX_TIMEOUT     = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       power,
  input  logic [3:0] moving_state,
  input  logic       place_req,
  input  logic       destroy_req,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] detector,
  output logic       detector_valid,
  output logic       link_lost
);

  localparam int RW = $clog2(REFRESH_CYCLES) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam int WW = $clog2(RX_TIMEOUT) + 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST     = GW'(GAP_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST      = WW'(RX_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t          state;
  logic            pend_dst;
  logic            pend_plc;
  logic [3:0]      last_sent;
  logic [3:0]      eff_ms;
  logic [RW-1:0]   refresh_cnt;
  logic [2:0]      wait_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [WW-1:0]   wd_cnt;
  logic            req;
  logic            rx_unused;

  assign eff_ms    = power ? moving_state : 4'b0000;
  assign req       = pend_dst | pend_plc | (eff_ms != last_sent) | (refresh_cnt == REFRESH_LAST);
  assign rx_unused = ^rx_data[7:4];

  // Any frame carries the current moving field, so one launch satisfies every request class.
  // Pulses arriving on the launching edge are kept for the following frame.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      tx_data     <= 8'h80;
      tx_start    <= 1'b0;
      pend_dst    <= 1'b0;
      pend_plc    <= 1'b0;
      last_sent   <= 4'b0000;
      refresh_cnt <= '0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
    end else begin
      tx_start <= 1'b0;
      pend_dst <= pend_dst | destroy_req;
      pend_plc <= pend_plc | place_req;
      case (state)
        IDLE: begin
          if (req) begin
            state       <= LAUNCH;
            tx_start    <= 1'b1;
            tx_data     <= {2'b10, pend_dst, pend_plc, eff_ms};
            last_sent   <= eff_ms;
            refresh_cnt <= '0;
            pend_dst    <= destroy_req;
            pend_plc    <= place_req;
          end else if (refresh_cnt != REFRESH_LAST) begin
            refresh_cnt <= refresh_cnt + 1'b1;
          end
        end
        LAUNCH: begin
          state    <= WAIT_BUSY;
          wait_cnt <= '0;
          gap_cnt  <= '0;
        end
        // A core that never raises busy must not stall the link; the frame counts as sent.
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (wait_cnt == 3'd7) begin
            state <= GAP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= GAP;
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RX_FILTER_EN
  logic       armed;
  logic [3:0] prev_nib;

  // Detector only follows a nibble seen twice in a row; the watchdog still sees every byte.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      detector       <= 4'h0;
      detector_valid <= 1'b0;
      link_lost      <= 1'b0;
      wd_cnt         <= '0;
      armed          <= 1'b0;
      prev_nib       <= 4'h0;
    end else if (rx_valid) begin
      wd_cnt         <= '0;
      detector_valid <= 1'b1;
      link_lost      <= 1'b0;
      armed          <= 1'b1;
      prev_nib       <= rx_data[3:0];
      if (armed && (rx_data[3:0] == prev_nib)) detector <= rx_data[3:0];
    end else if (wd_cnt == WD_LAST) begin
      link_lost      <= 1'b1;
      detector_valid <= 1'b0;
      armed          <= 1'b0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  // A received byte wins over a timeout landing in the same cycle.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      detector       <= 4'h0;
      detector_valid <= 1'b0;
      link_lost      <= 1'b0;
      wd_cnt         <= '0;
    end else if (rx_valid) begin
      wd_cnt         <= '0;
      detector_valid <= 1'b1;
      link_lost      <= 1'b0;
      detector       <= rx_data[3:0];
    end else if (wd_cnt == WD_LAST) begin
      link_lost      <= 1'b1;
      detector_valid <= 1'b0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_link_scheduler.sv
// Scoreboard bench for uart_link_scheduler: a transaction-level link model predicts frames
// and detector outputs; a negedge monitor compares them against the design.
module tb_uart_link_scheduler;

  localparam int R = 20;
  localparam int G = 4;
  localparam int T = 50;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b0;
  logic       power = 1'b0;
  logic [3:0] moving_state = 4'h0;
  logic       place_req = 1'b0;
  logic       destroy_req = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [3:0] detector;
  logic       detector_valid;
  logic       link_lost;

  uart_link_scheduler #(.REFRESH_CYCLES(R), .GAP_CYCLES(G), .RX_TIMEOUT(T)) dut (
    .sys_clk(sys_clk), .rst(rst), .power(power), .moving_state(moving_state),
    .place_req(place_req), .destroy_req(destroy_req), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_start(tx_start), .rx_data(rx_data), .rx_valid(rx_valid),
    .detector(detector), .detector_valid(detector_valid), .link_lost(link_lost)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    int         at;
  } frame_t;
  frame_t exp_q[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  // UART core stand-in: busy for 10 cycles starting one cycle after the launch strobe.
  int busy_cnt = 0;
  bit uart_mute = 1'b0;
  always @(posedge sys_clk) begin
    #1;
    if (!rst) begin
      busy_cnt = 0;
      tx_busy  = 1'b0;
    end else begin
      if (busy_cnt > 0) begin
        tx_busy = 1'b1;
        busy_cnt--;
      end else begin
        tx_busy = 1'b0;
      end
      if (tx_start && !uart_mute) busy_cnt = 10;
    end
  end

  // Reference model, evaluated at the end of each cycle from that cycle's inputs.
  logic       m_dst, m_plc;
  logic [3:0] m_last, m_prev, eff;
  int         m_idle_seen, m_launch, m_rise, m_idle_from, m_silent;
  bit         m_flight, m_rose, m_armed, idle;
  logic [3:0] e_det;
  logic       e_dv, e_lost;
  logic [7:0] e_hold;
  logic [7:0] fbyte;

  always @(posedge sys_clk) begin
    if (!rst) begin
      exp_q.delete();
      m_dst = 0; m_plc = 0; m_last = 4'h0; m_idle_seen = 0;
      m_flight = 0; m_rose = 0; m_idle_from = 0; m_launch = 0; m_rise = 0;
      m_silent = 0; m_armed = 0; m_prev = 4'h0;
      e_det = 4'h0; e_dv = 1'b0; e_lost = 1'b0; e_hold = 8'h80;
    end else begin
      eff = power ? moving_state : 4'h0;
      if (m_flight) begin
        if (!m_rose) begin
          if (tx_busy && cyc >= m_launch + 1) begin
            m_rose = 1; m_rise = cyc;
          end else if (cyc == m_launch + 8) begin
            m_flight = 0; m_idle_from = cyc + 1 + G;
          end
        end else if (!tx_busy && cyc > m_rise) begin
          m_flight = 0; m_idle_from = cyc + 1 + G;
        end
      end
      idle = !m_flight && (cyc >= m_idle_from);
      if (idle && (m_dst || m_plc || (eff != m_last) || (m_idle_seen >= R - 1))) begin
        fbyte = {2'b10, m_dst, m_plc, eff};
        exp_q.push_back('{data: fbyte, at: cyc + 1});
        e_hold = fbyte;
        m_last = eff; m_idle_seen = 0; m_dst = 0; m_plc = 0;
        m_flight = 1; m_rose = 0; m_launch = cyc + 1;
      end else if (idle) begin
        m_idle_seen++;
      end
      m_dst = m_dst | destroy_req;
      m_plc = m_plc | place_req;

      if (rx_valid) begin
        m_silent = 0; e_dv = 1'b1; e_lost = 1'b0;
`ifdef RX_FILTER_EN
        if (m_armed && rx_data[3:0] == m_prev) e_det = rx_data[3:0];
        m_prev = rx_data[3:0];
        m_armed = 1;
`else
        e_det = rx_data[3:0];
`endif
      end else begin
        m_silent++;
        if (m_silent >= T) begin
          e_lost = 1'b1; e_dv = 1'b0; m_armed = 0;
        end
      end
    end
    cyc = cyc + 1;
  end

  // Monitor: pops one expected frame per launch strobe and checks steady outputs each cycle.
  frame_t f;
  always @(negedge sys_clk) begin
    if (!rst) begin
      checkOutput("rst_tx_data", {24'h0, tx_data}, 32'h80);
      checkOutput("rst_tx_start", {31'h0, tx_start}, 32'h0);
      checkOutput("rst_detector", {28'h0, detector}, 32'h0);
      checkOutput("rst_detector_valid", {31'h0, detector_valid}, 32'h0);
      checkOutput("rst_link_lost", {31'h0, link_lost}, 32'h0);
    end else begin
      if (tx_start) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_frame actual=%0h required=none cycle=%0d", tx_data, cyc);
        end else begin
          f = exp_q.pop_front();
          checkOutput("frame_byte", {24'h0, tx_data}, {24'h0, f.data});
          checkOutput("frame_cycle", cyc, f.at);
        end
      end else if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        f = exp_q.pop_front();
        total++; bad++;
        $display("[TB] FAIL missing_frame actual=none required=%0h cycle=%0d", f.data, f.at);
      end
      checkOutput("tx_data_hold", {24'h0, tx_data}, {24'h0, e_hold});
      checkOutput("detector", {28'h0, detector}, {28'h0, e_det});
      checkOutput("detector_valid", {31'h0, detector_valid}, {31'h0, e_dv});
      checkOutput("link_lost", {31'h0, link_lost}, {31'h0, e_lost});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input bit plc, input bit dst);
    place_req = plc; destroy_req = dst;
    tick(1);
    place_req = 1'b0; destroy_req = 1'b0;
  endtask

  task automatic sendRx(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic waitLaunch();
    int n = 0;
    while (tx_start !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("[TB] FAIL launch_wait actual=timeout required=tx_start cycle=%0d", cyc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout actual=running required=finished cycle=%0d", cyc);
    $fatal(1, "[TB] simulation bound exceeded");
  end

  bit rx_on;
  initial begin
    tick(3);
    rst = 1'b1; power = 1'b1; moving_state = 4'h1;
    tick(60);

    waitLaunch(); tick(3);
    moving_state = 4'h2;
    applyStimulus(1'b1, 1'b1);
    tick(40);

    waitLaunch(); tick(2);
    applyStimulus(1'b1, 1'b0); tick(2);
    applyStimulus(1'b1, 1'b0);
    tick(40);

    applyStimulus(1'b1, 1'b0); tick(1);
    applyStimulus(1'b1, 1'b0);
    tick(60);

    moving_state = 4'h8; tick(40);
    power = 1'b0; tick(80);

    sendRx(8'hA5); tick(55);
    sendRx(8'h3C); tick(55);
    sendRx(8'h03); tick(2);
    sendRx(8'h05); tick(2);
    sendRx(8'h05); tick(5);

    uart_mute = 1'b1; power = 1'b1; moving_state = 4'h3;
    tick(40);
    uart_mute = 1'b0;

    moving_state = 4'h4;
    waitLaunch(); tick(4);
    rst = 1'b0; tick(3);
    rst = 1'b1; tick(30);

    rx_on = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      place_req   = ($urandom_range(0, 15) == 0);
      destroy_req = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) moving_state = 4'($urandom);
      if ($urandom_range(0, 99) == 0) power = ~power;
      if ($urandom_range(0, 119) == 0) rx_on = ~rx_on;
      uart_mute = ($urandom_range(0, 499) == 0) ? ~uart_mute : uart_mute;
      rx_valid = rx_on && ($urandom_range(0, 3) == 0);
      rx_data  = {4'($urandom), 2'b00, 2'($urandom)};
      tick(1);
    end
    place_req = 1'b0; destroy_req = 1'b0; rx_valid = 1'b0; uart_mute = 1'b0;
    tick(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
